// File: rtl/conv_pkg.sv
// Shared constants, widths, FSM encodings and config decode for the CONV stream feeder.
package conv_pkg;

  // Geometry of the engine input protocol
  localparam int unsigned IMG_W        = 64;
  localparam int unsigned KW           = 4;
  localparam int unsigned NUM_WIN      = IMG_W - KW + 1;
  localparam int unsigned PAIRS        = IMG_W / 2;
  localparam int unsigned BEATS_PER_CH = 2 + NUM_WIN * PAIRS;
  localparam int unsigned LEN_IN       = 8;
  localparam int unsigned LANES        = 8;

  // Bus and address widths, sized for the 32x32 channel/kernel maximum
  localparam int unsigned KRN_AW = 11;
  localparam int unsigned FM_AW  = 17;
  localparam int unsigned KRN_DW = LANES * LEN_IN;
  localparam int unsigned FM_DW  = 4 * LEN_IN;
  localparam int unsigned CFG_W  = 2;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned R_W    = 6;
  localparam int unsigned J_W    = 5;

  // Lane bundle presented to the engine, lane 0 in the low byte
  typedef logic [LANES-1:0][LEN_IN-1:0] lane_word_t;

  // FSM encodings
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PRIME    = 2'd1;
  localparam logic [1:0] ST_STREAM   = 2'd2;
  localparam logic [1:0] ST_WAIT_END = 2'd3;

  // 2-bit config code to channel/kernel count: 0..3 -> 8/16/24/32
  function automatic logic [CNT_W-1:0] cfg_count(input logic [CFG_W-1:0] code);
    return CNT_W'({code, 3'b000}) + CNT_W'(8);
  endfunction

endpackage

// File: rtl/conv_feed_addr_gen.sv
// Beat sequencer: walks k/ch/{kernel b | r/j} and produces memory addresses
// plus the valid/type/last flags aligned with the returned memory data.
module conv_feed_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned FM_W = IMG_W,
  parameter int unsigned K_W  = KW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [CFG_W-1:0]  ci_code,
  input  logic [CFG_W-1:0]  co_code,
  output logic [KRN_AW-1:0] krn_addr,
  output logic [FM_AW-1:0]  fm_addr0,
  output logic [FM_AW-1:0]  fm_addr1,
  output logic              lane_valid,
  output logic              lane_is_krn,
  output logic              lane_last
);

  localparam int unsigned N_WIN  = FM_W - K_W + 1;
  localparam int unsigned N_PAIR = FM_W / 2;

  logic [IDX_W-1:0]  k_q, k_d, ch_q, ch_d;
  logic              b_q, b_d;
  logic [R_W-1:0]    r_q, r_d;
  logic [J_W-1:0]    j_q, j_d;
  logic              krn_q, krn_d;
  logic              iss_q, iss_d;
  logic [KRN_AW-1:0] krn_addr_q, krn_addr_d;
  logic [FM_AW-1:0]  fm0_q, fm0_d, fm1_q, fm1_d;
  logic              vld1_q, vld1_d, typ1_q, typ1_d, last1_q, last1_d;

  logic [CNT_W-1:0]  n_ci, n_co;
  logic              last_c, step_c;
  logic [KRN_AW-1:0] krn_idx_c;
  logic [FM_AW-1:0]  fm_row_c;

  // Counter advance, address generation for the next beat, data-stage flag pipeline
  always_comb begin
    n_ci       = cfg_count(ci_code);
    n_co       = cfg_count(co_code);
    k_d        = k_q;
    ch_d       = ch_q;
    b_d        = b_q;
    r_d        = r_q;
    j_d        = j_q;
    krn_d      = krn_q;
    iss_d      = iss_q;
    krn_addr_d = krn_addr_q;
    fm0_d      = fm0_q;
    fm1_d      = fm1_q;
    step_c     = 1'b0;
    krn_idx_c  = '0;
    fm_row_c   = '0;

    last_c = iss_q && !krn_q
             && (j_q == J_W'(N_PAIR - 1))
             && (r_q == R_W'(N_WIN - 1))
             && ({1'b0, ch_q} == n_ci - CNT_W'(1))
             && ({1'b0, k_q} == n_co - CNT_W'(1));

    if (load) begin
      k_d    = '0;
      ch_d   = '0;
      b_d    = 1'b0;
      r_d    = '0;
      j_d    = '0;
      krn_d  = 1'b1;
      iss_d  = 1'b1;
      step_c = 1'b1;
    end else if (iss_q) begin
      if (last_c) begin
        iss_d = 1'b0;
      end else begin
        step_c = 1'b1;
        if (krn_q) begin
          if (!b_q) begin
            b_d = 1'b1;
          end else begin
            b_d   = 1'b0;
            krn_d = 1'b0;
            r_d   = '0;
            j_d   = '0;
          end
        end else if (j_q != J_W'(N_PAIR - 1)) begin
          j_d = j_q + J_W'(1);
        end else begin
          j_d = '0;
          if (r_q != R_W'(N_WIN - 1)) begin
            r_d = r_q + R_W'(1);
          end else begin
            r_d   = '0;
            krn_d = 1'b1;
            if ({1'b0, ch_q} != n_ci - CNT_W'(1)) begin
              ch_d = ch_q + IDX_W'(1);
            end else begin
              ch_d = '0;
              k_d  = k_q + IDX_W'(1);
            end
          end
        end
      end
    end

    // Only the address of the active beat type moves; the other one holds
    if (step_c) begin
      if (krn_d) begin
        krn_idx_c  = KRN_AW'(k_d) * KRN_AW'(n_ci) + KRN_AW'(ch_d);
        krn_addr_d = {krn_idx_c[KRN_AW-2:0], b_d};
      end else begin
        fm_row_c = FM_AW'(ch_d) * FM_AW'(N_WIN) + FM_AW'(r_d);
        fm0_d    = fm_row_c * FM_AW'(FM_W) + FM_AW'({j_d, 1'b0});
        fm1_d    = fm0_d + FM_AW'(1);
      end
    end

    vld1_d  = iss_q;
    typ1_d  = krn_q;
    last1_d = last_c;
  end

  // Counter, address and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q        <= '0;
      ch_q       <= '0;
      b_q        <= 1'b0;
      r_q        <= '0;
      j_q        <= '0;
      krn_q      <= 1'b0;
      iss_q      <= 1'b0;
      krn_addr_q <= '0;
      fm0_q      <= '0;
      fm1_q      <= '0;
      vld1_q     <= 1'b0;
      typ1_q     <= 1'b0;
      last1_q    <= 1'b0;
    end else begin
      k_q        <= k_d;
      ch_q       <= ch_d;
      b_q        <= b_d;
      r_q        <= r_d;
      j_q        <= j_d;
      krn_q      <= krn_d;
      iss_q      <= iss_d;
      krn_addr_q <= krn_addr_d;
      fm0_q      <= fm0_d;
      fm1_q      <= fm1_d;
      vld1_q     <= vld1_d;
      typ1_q     <= typ1_d;
      last1_q    <= last1_d;
    end
  end

  assign krn_addr    = krn_addr_q;
  assign fm_addr0    = fm0_q;
  assign fm_addr1    = fm1_q;
  assign lane_valid  = vld1_q;
  assign lane_is_krn = typ1_q;
  assign lane_last   = last1_q;

endmodule

// File: rtl/conv_stream_feeder.sv
// Transmit side of the CONV engine input protocol: FSM, config/start lines and lane registers.
module conv_stream_feeder
  import conv_pkg::*;
#(
  parameter int unsigned FM_W = IMG_W,
  parameter int unsigned K_W  = KW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [1:0]        cfg_ci,
  input  logic [1:0]        cfg_co,
  output logic              busy,
  output logic              done,
  output logic [10:0]       krn_addr,
  input  logic [63:0]       krn_rdata,
  output logic [16:0]       fm_addr0,
  output logic [16:0]       fm_addr1,
  input  logic [31:0]       fm_rdata0,
  input  logic [31:0]       fm_rdata1,
  output logic              out_start_conv,
  output logic [2:0]        out_cfg_ci,
  output logic [2:0]        out_cfg_co,
  output logic [7:0]        out_data0,
  output logic [7:0]        out_data1,
  output logic [7:0]        out_data2,
  output logic [7:0]        out_data3,
  output logic [7:0]        out_data4,
  output logic [7:0]        out_data5,
  output logic [7:0]        out_data6,
  output logic [7:0]        out_data7,
  input  logic              in_end_conv
);

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_q, start_d;
  logic [CFG_W-1:0] cfg_ci_q, cfg_ci_d, cfg_co_q, cfg_co_d;
  lane_word_t       lane_q, lane_d;

  logic             load_c;
  logic             lane_valid, lane_is_krn, lane_last;

  assign load_c = (state_q == ST_IDLE) && go;

  conv_feed_addr_gen #(
    .FM_W (FM_W),
    .K_W  (K_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load_c),
    .ci_code     (cfg_ci_q),
    .co_code     (cfg_co_q),
    .krn_addr    (krn_addr),
    .fm_addr0    (fm_addr0),
    .fm_addr1    (fm_addr1),
    .lane_valid  (lane_valid),
    .lane_is_krn (lane_is_krn),
    .lane_last   (lane_last)
  );

  // Next-state, handshake lines and lane select
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    start_d  = start_q;
    cfg_ci_d = cfg_ci_q;
    cfg_co_d = cfg_co_q;
    lane_d   = '0;

    if (lane_valid) begin
      lane_d = lane_is_krn ? lane_word_t'(krn_rdata) : lane_word_t'({fm_rdata1, fm_rdata0});
    end

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d  = ST_PRIME;
          busy_d   = 1'b1;
          cfg_ci_d = cfg_ci;
          cfg_co_d = cfg_co;
        end
      end
      ST_PRIME: begin
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // start rises together with the first beat on the lanes
        if (lane_valid) begin
          start_d = 1'b1;
        end
        if (lane_last) begin
          state_d = ST_WAIT_END;
        end
      end
      ST_WAIT_END: begin
        if (in_end_conv) begin
          start_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      cfg_ci_q <= '0;
      cfg_co_q <= '0;
      lane_q   <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      start_q  <= start_d;
      cfg_ci_q <= cfg_ci_d;
      cfg_co_q <= cfg_co_d;
      lane_q   <= lane_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign out_start_conv = start_q;
  assign out_cfg_ci     = {1'b0, cfg_ci_q};
  assign out_cfg_co     = {1'b0, cfg_co_q};
  assign out_data0      = lane_q[0];
  assign out_data1      = lane_q[1];
  assign out_data2      = lane_q[2];
  assign out_data3      = lane_q[3];
  assign out_data4      = lane_q[4];
  assign out_data5      = lane_q[5];
  assign out_data6      = lane_q[6];
  assign out_data7      = lane_q[7];

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Scoreboard bench: a full-size feeder for addressing/boundaries and a reduced
// 8x8-fmap feeder that runs a complete stream through WAIT_END and done.
module tb_conv_stream_feeder;
  import conv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full-size instance
  logic        rst_n, go, in_end_conv;
  logic [1:0]  cfg_ci, cfg_co;
  logic        busy, done, out_start_conv;
  logic [10:0] krn_addr;
  logic [63:0] krn_rdata;
  logic [16:0] fm_addr0, fm_addr1;
  logic [31:0] fm_rdata0, fm_rdata1;
  logic [2:0]  out_cfg_ci, out_cfg_co;
  logic [7:0]  d0, d1, d2, d3, d4, d5, d6, d7;

  // Reduced instance
  logic        rst_n_s, go_s, in_end_s;
  logic [1:0]  cfg_ci_s, cfg_co_s;
  logic        busy_s, done_s, start_s;
  logic [10:0] krn_addr_s;
  logic [63:0] krn_rdata_s;
  logic [16:0] fm_addr0_s, fm_addr1_s;
  logic [31:0] fm_rdata0_s, fm_rdata1_s;
  logic [2:0]  cfg_ci_o_s, cfg_co_o_s;
  logic [7:0]  s0, s1, s2, s3, s4, s5, s6, s7;

  logic [63:0] lanes_m, lanes_s;
  assign lanes_m = {d7, d6, d5, d4, d3, d2, d1, d0};
  assign lanes_s = {s7, s6, s5, s4, s3, s2, s1, s0};

  conv_stream_feeder u_dut (
    .clk(clk), .rst_n(rst_n), .go(go), .cfg_ci(cfg_ci), .cfg_co(cfg_co),
    .busy(busy), .done(done), .krn_addr(krn_addr), .krn_rdata(krn_rdata),
    .fm_addr0(fm_addr0), .fm_addr1(fm_addr1), .fm_rdata0(fm_rdata0), .fm_rdata1(fm_rdata1),
    .out_start_conv(out_start_conv), .out_cfg_ci(out_cfg_ci), .out_cfg_co(out_cfg_co),
    .out_data0(d0), .out_data1(d1), .out_data2(d2), .out_data3(d3),
    .out_data4(d4), .out_data5(d5), .out_data6(d6), .out_data7(d7),
    .in_end_conv(in_end_conv)
  );

  conv_stream_feeder #(.FM_W(8), .K_W(4)) u_sml (
    .clk(clk), .rst_n(rst_n_s), .go(go_s), .cfg_ci(cfg_ci_s), .cfg_co(cfg_co_s),
    .busy(busy_s), .done(done_s), .krn_addr(krn_addr_s), .krn_rdata(krn_rdata_s),
    .fm_addr0(fm_addr0_s), .fm_addr1(fm_addr1_s), .fm_rdata0(fm_rdata0_s), .fm_rdata1(fm_rdata1_s),
    .out_start_conv(start_s), .out_cfg_ci(cfg_ci_o_s), .out_cfg_co(cfg_co_o_s),
    .out_data0(s0), .out_data1(s1), .out_data2(s2), .out_data3(s3),
    .out_data4(s4), .out_data5(s5), .out_data6(s6), .out_data7(s7),
    .in_end_conv(in_end_s)
  );

  // Address-tagged memory contents
  function automatic logic [63:0] krn_word(input logic [10:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'(a >> i) ^ 8'(41 * i);
    return w;
  endfunction

  function automatic logic [31:0] fm_word(input logic [16:0] a, input bit sel);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(a >> (3 * i)) ^ 8'((sel ? 90 : 195) + 13 * i);
    return w;
  endfunction

  // Synchronous-read memories, one cycle of latency
  always @(posedge clk) begin
    krn_rdata   <= krn_word(krn_addr);
    fm_rdata0   <= fm_word(fm_addr0, 1'b0);
    fm_rdata1   <= fm_word(fm_addr1, 1'b1);
    krn_rdata_s <= krn_word(krn_addr_s);
    fm_rdata0_s <= fm_word(fm_addr0_s, 1'b0);
    fm_rdata1_s <= fm_word(fm_addr1_s, 1'b1);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int beat    = 0;
  logic [63:0] q_m[$];
  logic [63:0] q_s[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected lane words of a run, in engine beat order, up to nmax beats
  task automatic push_run(input bit sml, input int imgw, input int ci, input int co, input int nmax);
    int nwin, pairs, n, a;
    logic [63:0] w;
    nwin  = imgw - 3;
    pairs = imgw / 2;
    n     = 0;
    for (int k = 0; k < co; k++)
      for (int ch = 0; ch < ci; ch++) begin
        for (int b = 0; b < 2; b++) begin
          if (n >= nmax) return;
          w = krn_word(11'((k * ci + ch) * 2 + b));
          if (sml) q_s.push_back(w); else q_m.push_back(w);
          n++;
        end
        for (int r = 0; r < nwin; r++)
          for (int j = 0; j < pairs; j++) begin
            if (n >= nmax) return;
            a = (ch * nwin + r) * imgw + 2 * j;
            w = {fm_word(17'(a + 1), 1'b1), fm_word(17'(a), 1'b0)};
            if (sml) q_s.push_back(w); else q_m.push_back(w);
            n++;
          end
      end
  endtask

  task automatic wait_beat(input int n);
    while (beat < n) begin
      @(negedge clk);
      beat++;
    end
  endtask

  function automatic logic [63:0] ctl_m();
    return 64'({busy, done, out_start_conv, out_cfg_ci, out_cfg_co, krn_addr, fm_addr0, fm_addr1});
  endfunction

  // Monitor for the full-size instance
  always @(negedge clk) begin
    logic [63:0] e;
    if (out_start_conv) begin
      if (q_m.size() > 0) begin
        e = q_m.pop_front();
        chk("main lanes", lanes_m, e);
      end else begin
        chk("main lanes after stream", lanes_m, 64'd0);
      end
    end else begin
      chk("main lanes idle", lanes_m, 64'd0);
    end
  end

  // Monitor for the reduced instance
  always @(negedge clk) begin
    logic [63:0] e;
    if (start_s) begin
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        chk("sml lanes", lanes_s, e);
      end else begin
        chk("sml lanes after stream", lanes_s, 64'd0);
      end
    end else begin
      chk("sml lanes idle", lanes_s, 64'd0);
    end
  end

  task automatic reset_main_mid_cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("async reset ctl", ctl_m(), 64'd0);
    chk("async reset lanes", lanes_m, 64'd0);
    q_m.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no done after reset", 64'(done), 64'd0);
  endtask

  task automatic go_main(input logic [1:0] ci, input logic [1:0] co);
    @(negedge clk);
    cfg_ci = ci;
    cfg_co = co;
    go     = 1'b1;
    @(negedge clk);
    go   = 1'b0;
    beat = 0;
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; in_end_conv = 1'b0; cfg_ci = 2'd0; cfg_co = 2'd0;
    rst_n_s = 1'b0; go_s = 1'b0; in_end_s = 1'b0; cfg_ci_s = 2'd0; cfg_co_s = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rst_n_s = 1'b1;
    @(negedge clk);
    chk("reset ctl", ctl_m(), 64'd0);
    chk("reset sml ctl", 64'({busy_s, done_s, start_s, cfg_ci_o_s, cfg_co_o_s}), 64'd0);

    // Run 1: cfg 0/0, timing and fmap addressing, reset at beat 5000
    push_run(1'b0, 64, 8, 8, 5100);
    go_main(2'd0, 2'd0);
    chk("busy on go edge", 64'(busy), 64'd1);
    chk("start low beat0 addr", 64'(out_start_conv), 64'd0);
    chk("krn_addr beat0", 64'(krn_addr), 64'd0);
    wait_beat(1);
    chk("start low 1 edge", 64'(out_start_conv), 64'd0);
    chk("krn_addr beat1", 64'(krn_addr), 64'd1);
    wait_beat(2);
    chk("start high 2 edges", 64'(out_start_conv), 64'd1);
    chk("fm_addr beat2", 64'({fm_addr0, fm_addr1}), 64'({17'd0, 17'd1}));
    chk("cfg out 0/0", 64'({out_cfg_ci, out_cfg_co}), 64'd0);
    wait_beat(33);
    chk("fm_addr beat33", 64'({fm_addr0, fm_addr1}), 64'({17'd62, 17'd63}));
    wait_beat(34);
    chk("fm_addr beat34", 64'({fm_addr0, fm_addr1}), 64'({17'd64, 17'd65}));
    wait_beat(1954);
    chk("krn_addr beat1954", 64'(krn_addr), 64'd2);
    chk("fm hold beat1954", 64'(fm_addr0), 64'd3902);
    wait_beat(1956);
    chk("krn hold beat1956", 64'(krn_addr), 64'd3);
    chk("fm_addr beat1956", 64'(fm_addr0), 64'd3904);
    wait_beat(5000);
    reset_main_mid_cycle();

    // Run 2: cfg ci=16 co=8, restart after reset, ignored go/end/cfg mid-stream
    push_run(1'b0, 64, 16, 8, 31300);
    go_main(2'd1, 2'd0);
    chk("busy run2", 64'(busy), 64'd1);
    wait_beat(2);
    chk("start run2", 64'(out_start_conv), 64'd1);
    chk("cfg out 1/0", 64'({out_cfg_ci, out_cfg_co}), 64'h08);
    wait_beat(100);
    go = 1'b1; in_end_conv = 1'b1; cfg_ci = 2'd3; cfg_co = 2'd3;
    wait_beat(101);
    go = 1'b0; in_end_conv = 1'b0;
    chk("busy after stray end", 64'(busy), 64'd1);
    chk("cfg held while busy", 64'({out_cfg_ci, out_cfg_co}), 64'h08);
    wait_beat(1954);
    chk("krn_addr ch1", 64'(krn_addr), 64'd2);
    wait_beat(31264);
    chk("krn_addr k1", 64'(krn_addr), 64'd32);
    chk("fm hold k1", 64'(fm_addr0), 64'd62462);
    chk("start held run2", 64'(out_start_conv), 64'd1);
    wait_beat(31270);
    reset_main_mid_cycle();

    // Run 3: reduced 8x8 instance, full stream of 8*16*22 beats, WAIT_END and done
    push_run(1'b1, 8, 16, 8, 2816);
    @(negedge clk);
    cfg_ci_s = 2'd1; cfg_co_s = 2'd0; go_s = 1'b1;
    @(negedge clk);
    go_s = 1'b0;
    beat = 0;
    chk("sml busy on go", 64'(busy_s), 64'd1);
    wait_beat(2);
    chk("sml start", 64'(start_s), 64'd1);
    chk("sml cfg out", 64'({cfg_ci_o_s, cfg_co_o_s}), 64'h08);
    wait_beat(300);
    go_s = 1'b1; in_end_s = 1'b1; cfg_ci_s = 2'd0; cfg_co_s = 2'd2;
    wait_beat(301);
    go_s = 1'b0; in_end_s = 1'b0;
    wait_beat(2918);
    chk("sml start held in wait", 64'(start_s), 64'd1);
    chk("sml busy in wait", 64'(busy_s), 64'd1);
    chk("sml no early done", 64'(done_s), 64'd0);
    chk("sml beats left", 64'(q_s.size()), 64'd0);
    in_end_s = 1'b1;
    wait_beat(2919);
    in_end_s = 1'b0;
    chk("sml start drop", 64'(start_s), 64'd0);
    chk("sml done pulse", 64'(done_s), 64'd1);
    chk("sml busy drop", 64'(busy_s), 64'd0);
    wait_beat(2920);
    chk("sml done one cycle", 64'(done_s), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_stream_feeder.md
Name: conv_stream_feeder

Overview:
- Transmit end of the CONV engine input protocol. Fetches kernels and pre-tiled input feature maps from on-chip memories and drives the engine's 8-lane byte stream in the exact beat order the engine consumes.
- Owns the engine's start/config lines and holds start high until the engine reports end of convolution.
- Sits between the host/DMA-loaded buffers and the CONV top.

Parameters:
- IMG_W, 64, input fmap width/height in pixels.
- KW, 4, kernel width/height (fixed 4x4 beat format).
- NUM_WIN, IMG_W-KW+1 = 61, window rows per channel.
- PAIRS, IMG_W/2 = 32, column-pair beats per window row.
- LEN_IN, 8, data lane width in bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  start request; sampled only in IDLE.
- cfg_ci  in  2  channels: 0..3 means 8/16/24/32.
- cfg_co  in  2  kernels: 0..3 means 8/16/24/32.
- busy  out  1  high from go acceptance until done.
- done  out  1  one-cycle pulse at completion.
- krn_addr  out  11  kernel memory address; synchronous read, 1-cycle latency.
- krn_rdata  in  64  kernel word; byte i drives lane i.
- fm_addr0 / fm_addr1  out  17  fmap tile addresses for column c and column c+1.
- fm_rdata0 / fm_rdata1  in  32  tile words; byte i = fmap[r+i][c].
- out_start_conv  out  1  engine start.
- out_cfg_ci / out_cfg_co  out  3  engine config, {1'b0, cfg}.
- out_data0..out_data7  out  8  engine lanes.
- in_end_conv  in  1  engine completion.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-stream aborts immediately with no done pulse.
- States: IDLE -> PRIME -> STREAM -> WAIT_END -> IDLE.
- IDLE:
  - go=1 latches cfg, sets busy=1, moves to PRIME.
  - busy is registered, so it rises on the edge that accepts go.
- PRIME: issues the beat-0 address for one cycle.
- STREAM, one beat per cycle, no stalls (the engine has no backpressure):
  - Loop nesting: k 0..CO-1 { ch 0..CI-1 { kernel beat b=0,1; then r 0..60 { j 0..31 } } }.
  - Beats per (k,ch) = 2+61*32 = 1954. Total beats = CO*CI*1954.
- Kernel beat:
  - krn_addr = ((k*CI+ch)*2+b).
  - Lanes 0-3 = kernel row 2b, cols 0-3; lanes 4-7 = row 2b+1.
- Fmap beat:
  - c = 2j; fm_addr0 = (ch*NUM_WIN+r)*IMG_W+c; fm_addr1 = fm_addr0+1.
  - Lanes 0-3 = fm_rdata0 bytes 0-3; lanes 4-7 = fm_rdata1 bytes 0-3.
  - fm_addr0/fm_addr1 hold their previous value during kernel beats; krn_addr holds during fmap beats.
- Pipeline: address in cycle n, memory data at edge n+1, output lanes registered at edge n+2.
  - out_start_conv and beat 0 appear together, 2 edges after the edge that accepted go.
  - out_start_conv rises exactly with beat 0; the engine samples beat 0 on the next edge.
- Wrap-around:
  - j=31 wraps to j=0, r+1.
  - r=60 wraps to the next channel's kernel beat 0.
  - ch=CI-1 wraps to k+1.
  - The beat after the last one (k=CO-1, ch=CI-1, r=60, j=31) enters WAIT_END.
- WAIT_END:
  - Lanes driven 0; out_start_conv and cfg held.
  - in_end_conv=1 -> out_start_conv=0, done=1 for one cycle, busy=0, return to IDLE.
- Illegal or ignored inputs:
  - in_end_conv outside WAIT_END is ignored.
  - go while busy is ignored.
  - cfg changes while busy are ignored.
- Arithmetic: unsigned; address widths sized for the 32x32 maximum with no overflow. Lanes pass through unmodified.

Decomposition:
- conv_pkg:
  - Constants: IMG_W, KW, NUM_WIN, PAIRS, BEATS_PER_CH (1954), LEN_IN.
  - Address widths.
  - State enum.
  - cfg-decode function (2-bit code -> 8/16/24/32).
- Sub-module conv_feed_addr_gen:
  - Holds the k/ch/b/r/j counters and the address arithmetic.
  - Outputs addresses, a kernel/fmap beat-type flag (delayed 2 stages to select lanes) and a last-beat flag.
- Top module: FSM and output lane registers.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously.
- Timing and beat 0: go with cfg 0/0, memories preloaded with address-tagged patterns.
  - out_start_conv rises 2 edges after go.
  - Beat 0 lanes = krn word 0 bytes.
  - out_cfg_ci = out_cfg_co = 3'b000.
- Fmap addressing: beat 2 -> fm_addr0=0, fm_addr1=1; beat 34 (r=1, j=0) -> fm_addr0=64, fm_addr1=65; beat 33 (r=0, j=31) -> fm_addr0=62.
- Channel/kernel boundaries, cfg ci=1 co=0:
  - Beat 1954 is kernel beat b=0 with krn_addr=2.
  - Beat 31264 (k=1) has krn_addr=32.
  - Stream length = 8*16*1954 = 250112 beats, then lanes are 0.
- WAIT_END: hold in_end_conv=0 for 100 cycles -> out_start_conv stays 1. Pulse in_end_conv -> next edge out_start_conv=0, done=1 for 1 cycle, busy=0.
- Robustness:
  - go and in_end_conv pulses during STREAM -> no effect on beat order or count.
  - Reset at beat 5000, then a new go -> stream restarts from beat 0, no done pulse.
